// File: rtl/data_sram_slave_if.sv
// data_sram_slave_if: CPU data-side SRAM bus (request from master, registered read data back).
interface data_sram_slave_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output en, wen, addr, wdata, input rdata);
    modport slave (input en, wen, addr, wdata, output rdata);
endinterface

// File: rtl/data_sram_slave.sv
// data_sram_slave: word RAM plus an I/O page with timer/compare interrupt and LED register.
module data_sram_slave #(
    parameter int          ADDR_W  = 12,
    parameter logic [15:0] IO_BASE = 16'h1FAF
) (
    input  logic               clk,
    input  logic               reset,
    data_sram_slave_if.slave   bus,
    output logic               timer_irq,
    output logic [15:0]        led
);
    logic [31:0] mem [2**ADDR_W];
    logic [31:0] count, compare, io_rd;
    logic [ADDR_W-1:0] idx;
    logic [15:0] off;
    logic tmr_en, pend, io, wr, rd, wr_count, wr_cmp, wr_ctrl, wr_led, clr;

    function automatic logic [31:0] merge(input logic [31:0] o, d, input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? d[8*i +: 8] : o[8*i +: 8];
        return m;
    endfunction

    assign io        = bus.addr[31:16] == IO_BASE;
    assign off       = bus.addr[15:0];
    assign idx       = bus.addr[ADDR_W+1:2];
    assign wr        = bus.en && |bus.wen;
    assign rd        = bus.en && bus.wen == 4'h0;
    assign wr_count  = wr && io && off == 16'h0;
    assign wr_cmp    = wr && io && off == 16'h4;
    assign wr_ctrl   = wr && io && off == 16'h8;
    assign wr_led    = wr && io && off == 16'hC;
    assign clr       = (wr_ctrl && bus.wen[0] && bus.wdata[1]) || wr_cmp;
    assign timer_irq = pend;

    always_comb
        io_rd = off == 16'h0 ? count :
                off == 16'h4 ? compare :
                off == 16'h8 ? {30'b0, pend, tmr_en} :
                off == 16'hC ? {16'b0, led} : 32'h0;

    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (wr && !io && bus.wen[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];

    // Set of PEND takes priority over a same-cycle software clear.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bus.rdata <= '0;
            count     <= '0;
            compare   <= '1;
            tmr_en    <= 1'b0;
            pend      <= 1'b0;
            led       <= '0;
        end else begin
            if (rd) bus.rdata <= io ? io_rd : mem[idx];
            count <= wr_count ? merge(count, bus.wdata, bus.wen) : tmr_en ? count + 32'd1 : count;
            if (wr_cmp) compare <= merge(compare, bus.wdata, bus.wen);
            if (wr_ctrl && bus.wen[0]) tmr_en <= bus.wdata[0];
            pend <= (tmr_en && count == compare) || (pend && !clr);
            if (wr_led && bus.wen[0]) led[7:0] <= bus.wdata[7:0];
            if (wr_led && bus.wen[1]) led[15:8] <= bus.wdata[15:8];
        end
endmodule

// File: doc/data_sram_slave.md
Name: data_sram_slave

Overview:
- Responder for the CPU's data-side SRAM interface: accepts `data_sram_en`/`wen`/`addr`/`wdata` and returns `data_sram_rdata` one cycle later.
- Backed by a word-addressed RAM plus a small memory-mapped I/O page.
- The I/O page holds a free-running timer/compare unit and an LED register.
- The timer interrupt drives one `ext_int` line into CP0, so this block is the other end of the CPU's data-memory interface and the source of hardware interrupts.

Parameters:
- `ADDR_W`, 12, RAM word-address width (RAM depth = 2^ADDR_W words).
- `IO_BASE`, 16'h1FAF, value of `addr[31:16]` that selects the I/O page instead of RAM.

Ports:
- `clk`  input  1  system clock, all state updates on rising edge
- `reset`  input  1  asynchronous, active-high reset
- `data_sram_en`  input  1  access request this cycle
- `data_sram_wen`  input  4  byte write enables; 0 = read, nonzero = write of enabled lanes
- `data_sram_addr`  input  32  byte address; bits [1:0] ignored
- `data_sram_wdata`  input  32  write data, lane i = bits [8i+7:8i]
- `data_sram_rdata`  output  32  registered read data
- `timer_irq`  output  1  timer interrupt level, wired to `ext_int[5]`
- `led`  output  16  LED register bits [15:0]

Behaviour:

Reset (asynchronous, active-high):
- `data_sram_rdata` = 0, `timer_irq` = 0, `led` = 0.
- COUNT = 0, COMPARE = 32'hFFFFFFFF, CTRL = 0.
- RAM contents are not reset.

Decode:
- I/O access when `addr[31:16] == IO_BASE`.
- Otherwise RAM access at word index `addr[ADDR_W+1:2]`; upper address bits are aliased/ignored.

Reads (`en` = 1, `wen` = 0):
- `rdata` is updated at the rising edge and is valid the cycle after the request.
- Latency is fixed at 1 with no stall; back-to-back reads are allowed every cycle.
- `rdata` holds its value whenever there is no read (`en` = 0 or a write cycle).

Writes (`en` = 1, `wen` != 0):
- Only the enabled byte lanes are updated at the rising edge.
- A read in the next cycle to the same address returns the new data.

I/O page (offset = `addr[15:0]`):
- 0x0 COUNT (RW)
- 0x4 COMPARE (RW)
- 0x8 CTRL (RW): bit0 EN, bit1 PEND; other bits read 0.
- 0xC LED (RW): bits [15:0]; upper bits read 0.
- Any other offset reads 0; writes to it are ignored.
- Byte enables apply per lane to I/O registers.
- An I/O read returns the register value before any same-edge update.

Timer:
- When EN = 1, COUNT increments by 1 each cycle, wrapping 32'hFFFFFFFF -> 0.
- A software write to COUNT overrides the increment in that cycle.
- PEND sets at the edge after any cycle where EN = 1 and COUNT == COMPARE.
- PEND clears on a write with CTRL lane0 enabled and `wdata[1]` = 1 (W1C), or on any write to COMPARE.
- If set and clear occur in the same cycle, set wins.
- Writing `wdata[1]` = 0 to CTRL leaves PEND unchanged; PEND is never software-set.
- `timer_irq` = PEND, which is a registered level.
- EN = 0 freezes COUNT; PEND is retained.

Misc:
- `en` = 0 means no state change except the timer.
- Reset asserted mid-operation: all registers return to reset values immediately; an in-flight read result is discarded.

Test Plan:
1. Reset, then write 0xDEADBEEF to 0x0000_0010 with `wen` = 4'hF, then read it -> `rdata` = 0xDEADBEEF exactly one cycle after the read request; `rdata` unchanged during the write cycle.
2. Write `wen` = 4'b0101, `wdata` = 0x11223344 over 0xDEADBEEF at 0x10, then read -> 0xDE22BE44; back-to-back reads of 0x10 and 0x14 return each value on consecutive cycles.
3. Write COMPARE (0x1FAF0004) = 10, then CTRL = 1 -> `timer_irq` rises the cycle after COUNT reads 10 and stays high; writing CTRL = 3 clears it; reading COUNT returns a monotonically increasing value.
4. Write COUNT = 0xFFFFFFFE with EN = 1 and COMPARE = 0 -> COUNT wraps to 0 and PEND sets; in a separate run, a CTRL W1C in the same cycle as the set condition leaves PEND = 1.
5. Write LED (0x1FAF000C) = 0xFFFF00A5 -> `led` = 0x00A5, readback = 0x000000A5; read of 0x1FAF0020 -> 0; write to that offset has no effect.
6. Assert `reset` mid-stream while the timer is running and `timer_irq` = 1 -> `timer_irq`, `led`, `rdata` and COUNT are immediately 0; COMPARE reads 0xFFFFFFFF after release.
